twf_seq_gen: RTL and testbench

//  Parametrised twiddle-factor sequencer for the pipelined FFT datapath. On one start pulse it walks a

---
 rtl/twf_pkg.sv | 52 +++++
 rtl/twf_rom.sv | 31 +++
 rtl/twf_seq_gen.sv | 146 ++++++++++++++
 tb/tb_twf_seq_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/twf_pkg.sv
// twf_pkg: shared types and coefficient helpers for the twiddle-factor sequencer.
//   twf_state_e : sequencer states IDLE / RUN / WAIT_LAST
//   twf_coef    : twiddle coefficient k of a depth-point table, signed Q1.(dw-1),
//                 re = round(cos(2*pi*k/depth)), im = round(-sin(2*pi*k/depth)),
//                 both saturated to the signed dw-bit range (so +1.0 becomes max positive)
//   twf_neg_sat : saturating negation in a dw-bit signed range (-2^(dw-1) -> 2^(dw-1)-1)
// Used by twf_rom and twf_seq_gen (optional feature macro: TWF_CONJ_EN).
package twf_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_LAST = 2'd2
  } twf_state_e;

  localparam real TWO_PI = 6.283185307179586;

  // Elaboration-time table generator; every ROM entry is a constant.
  function automatic int twf_coef(input int k, input int depth, input int dw, input logic imag);
    real ang;
    real v;
    real scale;
    int  q;
    int  pmax;
    pmax  = (32'sd1 <<< (dw - 32'sd1)) - 32'sd1;
    scale = $itor(pmax + 32'sd1);
    ang   = TWO_PI * k / depth;
    if (imag) begin
      v = -$sin(ang);
    end else begin
      v = $cos(ang);
    end
    q = $rtoi($floor(v * scale + 0.5));
    if (q > pmax) begin
      q = pmax;
    end else if (q < -pmax - 32'sd1) begin
      q = -pmax - 32'sd1;
    end
    return q;
  endfunction

  function automatic int twf_neg_sat(input int v, input int dw);
    int pmax;
    pmax = (32'sd1 <<< (dw - 32'sd1)) - 32'sd1;
    if (-v > pmax) begin
      return pmax;
    end else begin
      return -v;
    end
  endfunction

endpackage

// File: rtl/twf_rom.sv
// twf_rom: one combinational twiddle lookup lane.
//   addr : table index {group, lane}
//   re   : signed real part of the coefficient
//   im   : signed imaginary part of the coefficient
// Contents come from twf_pkg::twf_coef, so the table is pure constants.
module twf_rom
  import twf_pkg::*;
#(
  parameter  int DW    = 10,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        [AW-1:0] addr,
  output logic signed [DW-1:0] re,
  output logic signed [DW-1:0] im
);

  logic [DW-1:0] tab_re [DEPTH];
  logic [DW-1:0] tab_im [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_tab
    localparam int RE_K = twf_coef(k, DEPTH, DW, 1'b0);
    localparam int IM_K = twf_coef(k, DEPTH, DW, 1'b1);
    assign tab_re[k] = RE_K[DW-1:0];
    assign tab_im[k] = IM_K[DW-1:0];
  end

  assign re = tab_re[addr];
  assign im = tab_im[addr];

endmodule

// File: rtl/twf_seq_gen.sv
// twf_seq_gen: twiddle-factor sequencer. One start pulse walks grp_cnt groups from
// grp_base (wrapping mod NGRP) and presents one registered group of LANES
// coefficients per beat on a valid/ready interface.
//   clk, rstn           : clock (rising edge), asynchronous active-low reset
//   start               : begin a run (sampled only in IDLE) with grp_base / grp_cnt
//   grp_cnt             : 0 or anything above NGRP means a full NGRP-group run
//   conj                : (TWF_CONJ_EN only) conjugate imaginary parts for the run
//   out_ready           : consumer accepts the current beat
//   out_valid, out_grp, out_last, re, im : registered beat
//   busy                : run in progress; done : one-cycle pulse after the last beat
// Optional feature macro: TWF_CONJ_EN (adds conj port, saturating -im).
module twf_seq_gen
  import twf_pkg::*;
#(
  parameter  int LANES = 16,
  parameter  int DW    = 10,
  parameter  int NGRP  = 32,
  localparam int GW    = $clog2(NGRP),
  localparam int LW    = $clog2(LANES)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [GW-1:0]              grp_base,
  input  logic [GW:0]                grp_cnt,
`ifdef TWF_CONJ_EN
  input  logic                       conj,
`endif
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [GW-1:0]              out_grp,
  output logic                       out_last,
  output logic [LANES-1:0][DW-1:0]   re,
  output logic [LANES-1:0][DW-1:0]   im,
  output logic                       busy,
  output logic                       done
);

  twf_state_e              state;
  logic [GW-1:0]           cur_grp;
  logic [GW:0]             remaining;
  logic [GW:0]             run_len;
  logic                    load;
  logic [LANES-1:0][DW-1:0] nxt_re;
  logic [LANES-1:0][DW-1:0] nxt_im;
`ifdef TWF_CONJ_EN
  logic                    conj_run;
`endif

  // The output slot takes a new group whenever it is empty or being drained.
  assign load = (state == RUN) && (!out_valid || out_ready);

  // Run length: 0 and oversize counts both mean a full table sweep.
  always_comb begin
    if ((grp_cnt == {(GW+1){1'b0}}) || (grp_cnt > (GW+1)'(NGRP))) begin
      run_len = (GW+1)'(NGRP);
    end else begin
      run_len = grp_cnt;
    end
  end

  // Address is a plain concatenation, so each lane has its own constant ROM.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DW-1:0] rom_re;
    logic signed [DW-1:0] rom_im;

    twf_rom #(
      .DW    (DW),
      .DEPTH (LANES * NGRP)
    ) u_rom (
      .addr ({cur_grp, LW'(l)}),
      .re   (rom_re),
      .im   (rom_im)
    );

    assign nxt_re[l] = rom_re;
`ifdef TWF_CONJ_EN
    assign nxt_im[l] = conj_run ? DW'(twf_neg_sat(int'(rom_im), DW)) : rom_im;
`else
    assign nxt_im[l] = rom_im;
`endif
  end

  // FSM, run counters and the single output register stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cur_grp   <= {GW{1'b0}};
      remaining <= {(GW+1){1'b0}};
      out_valid <= 1'b0;
      out_grp   <= {GW{1'b0}};
      out_last  <= 1'b0;
      re        <= '0;
      im        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef TWF_CONJ_EN
      conj_run  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            cur_grp   <= grp_base;
            remaining <= run_len;
`ifdef TWF_CONJ_EN
            conj_run  <= conj;
`endif
          end
        end
        RUN: begin
          if (load && (remaining == (GW+1)'(1))) begin
            state <= WAIT_LAST;
          end
        end
        WAIT_LAST: begin
          if (out_valid && out_ready && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (load) begin
        out_valid <= 1'b1;
        re        <= nxt_re;
        im        <= nxt_im;
        out_grp   <= cur_grp;
        out_last  <= (remaining == (GW+1)'(1));
        cur_grp   <= cur_grp + GW'(1);
        remaining <= remaining - (GW+1)'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_twf_seq_gen.sv
// tb_twf_seq_gen: randomized self-checking bench for twf_seq_gen. The reference model
// builds the expected beat list for each run from base/count arithmetic and computes
// coefficients directly from cos/sin.
module tb_twf_seq_gen;
  localparam int LANES = 16;
  localparam int DW    = 10;
  localparam int NGRP  = 32;
  localparam int GW    = 5;
  localparam int VW    = LANES * DW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [GW-1:0] grp_base = '0;
  logic [GW:0]   grp_cnt = '0;
`ifdef TWF_CONJ_EN
  logic conj = 1'b0;
`endif
  logic out_valid, out_last, busy, done;
  logic [GW-1:0] out_grp;
  logic [LANES-1:0][DW-1:0] re, im;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] g0_re, g0_im, g8_im;

  always #5 clk = ~clk;

  twf_seq_gen #(.LANES(LANES), .DW(DW), .NGRP(NGRP)) dut (
    .clk(clk), .rstn(rstn), .start(start), .grp_base(grp_base), .grp_cnt(grp_cnt),
`ifdef TWF_CONJ_EN
    .conj(conj),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .out_grp(out_grp), .out_last(out_last),
    .re(re), .im(im), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Coefficient k of the 512-point table: round(cos) / round(-sin) in Q1.9, saturated.
  function automatic int coef(input int k, input bit imag);
    real ang, v;
    int q;
    ang = 6.283185307179586 * k / (LANES * NGRP);
    if (imag) v = -$sin(ang);
    else      v = $cos(ang);
    q = $rtoi($floor(v * 512.0 + 0.5));
    if (q > 511)  q = 511;
    if (q < -512) q = -512;
    return q;
  endfunction

  function automatic logic [VW-1:0] exp_vec(input int grp, input bit imag, input bit cj);
    logic [VW-1:0] r;
    int v;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      v = coef(grp * LANES + l, imag);
      if (imag && cj) v = (v == -512) ? 511 : -v;
      r[l*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  // mode 0: always ready; 1: random ready plus ignored starts; 2: ready low cycles 4..6
  task automatic run(input int base, input int cnt, input int mode, input bit cj, input int abort_beat);
    int q_grp[$];
    int n, cyc, beat, first_cyc, g;
    bit fin, held, exp_done;
    logic [VW-1:0] h_re, h_im;
    logic [GW-1:0] h_grp;
    logic h_last;
    n = (cnt == 0 || cnt > NGRP) ? NGRP : cnt;
    for (int i = 0; i < n; i++) q_grp.push_back((base + i) % NGRP);
    @(negedge clk);
    start = 1'b1; grp_base = GW'(base); grp_cnt = (GW+1)'(cnt);
`ifdef TWF_CONJ_EN
    conj = cj;
`endif
    cyc = 0; beat = 0; first_cyc = -1; fin = 0; held = 0; exp_done = 0;
    h_re = '0; h_im = '0; h_grp = '0; h_last = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (abort_beat >= 0 && beat == abort_beat && out_valid) begin
        rstn = 1'b0; start = 1'b0; #1;
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_re", re, '0);
        @(negedge clk);
        check("rst_mid_done", done, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_mid_idle", out_valid, 1'b0);
        check("rst_mid_done2", done, 1'b0);
        return;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = !(cyc >= 4 && cyc <= 6);
      endcase
      check("done", done, exp_done);
      check("busy", busy, !exp_done);
      if (exp_done) begin
        check("done_valid", out_valid, 1'b0);
        fin = 1;
      end else begin
        if (held) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_grp", out_grp, h_grp);
          check("hold_last", out_last, h_last);
          check("hold_re", re, h_re);
          check("hold_im", im, h_im);
        end
        if (out_valid) begin
          if (first_cyc < 0) begin
            first_cyc = cyc;
            check("latency", cyc, 2);
          end
          if (q_grp.size() == 0) begin
            check("extra_beat", out_valid, 1'b0);
          end else begin
            g = q_grp[0];
            check("grp", out_grp, g);
            check("last", out_last, q_grp.size() == 1);
            check("re", re, exp_vec(g, 1'b0, 1'b0));
            check("im", im, exp_vec(g, 1'b1, cj));
            if (out_grp == 0) begin g0_re = re[0]; g0_im = im[0]; end
            if (out_grp == 8) g8_im = im[0];
            if (out_ready) begin
              void'(q_grp.pop_front());
              beat++;
              if (q_grp.size() == 0) exp_done = 1;
            end
          end
        end
        held = out_valid && !out_ready;
        h_re = re; h_im = im; h_grp = out_grp; h_last = out_last;
        if (cyc > 400) begin
          check("timeout", cyc, 0);
          fin = 1;
        end
      end
      start = (!exp_done && !fin && mode == 1 && $urandom_range(0, 3) == 0);
      grp_base = GW'($urandom_range(0, NGRP - 1));
      grp_cnt  = (GW+1)'($urandom_range(0, 2 * NGRP - 1));
    end
    start = 1'b0;
    check("beats", beat, n);
  endtask

  initial begin
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_re", re, '0);
    check("rst_im", im, '0);
    check("rst_grp", out_grp, '0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_valid", out_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
    end

    run(0, 4, 0, 1'b0, -1);
    check("g0_lane0_re", g0_re, 10'd511);
    check("g0_lane0_im", g0_im, 10'd0);
    run(0, 8, 2, 1'b0, -1);
    run(30, 4, 0, 1'b0, -1);
    run(0, 0, 1, 1'b0, -1);
    check("g8_lane0_im", g8_im, 10'h200);
    run(5, 40, 1, 1'b0, -1);
    run(3, 8, 0, 1'b0, 3);
    run(3, 8, 0, 1'b0, -1);
    for (int i = 0; i < 6; i++)
      run($urandom_range(0, NGRP - 1), $urandom_range(0, 2 * NGRP - 1), 1, 1'b0, -1);
`ifdef TWF_CONJ_EN
    run(0, 16, 1, 1'b1, -1);
    check("conj_g8_im", g8_im, 10'd511);
    run(0, 16, 0, 1'b0, -1);
    check("plain_g8_im", g8_im, 10'h200);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
